// File: rtl/sum_pkg.sv
// Shared types for the sumItUp batch feeder.
// Operand width must match the accumulator.
package sum_pkg;
  localparam int W = 8;
  typedef logic [W-1:0] word_t;
  typedef enum logic [1:0] {
    IDLE,
    GO,
    STREAM
  } feed_state_t;
endpackage

// File: rtl/sum_feeder_op_fifo.sv
// Operand FIFO for the feeder.
// Pointers carry one extra bit to tell full from empty.
module op_fifo
  import sum_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic  ck,
  input  logic  reset_l,
  input  logic  push,
  input  word_t wr_data,
  input  logic  pop,
  output word_t head,
  output logic  full,
  output logic  empty
);
  localparam int AW = $clog2(DEPTH);

  word_t         mem [DEPTH];
  logic [AW:0]   wp_q, wp_d;
  logic [AW:0]   rp_q, rp_d;
  logic          do_push, do_pop;

  assign empty   = (wp_q == rp_q);
  assign full    = (wp_q[AW] != rp_q[AW]) &&
                   (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign head    = mem[rp_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // next pointer values; wrap falls out of the modulo width
  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (do_push) wp_d = wp_q + 1'b1;
    if (do_pop)  rp_d = rp_q + 1'b1;
  end

  // pointer state
  always_ff @(posedge ck or negedge reset_l) begin
    if (!reset_l) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  // storage needs no reset; pointers define validity
  always_ff @(posedge ck) begin
    if (do_push) mem[wp_q[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/sum_feeder.sv
// Initiator for the sumItUp accumulate protocol.
// Streams a FIFO batch, terminates it, captures and checks the sum.
module sum_feeder
  import sum_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic  ck,
  input  logic  reset_l,
  input  logic  wr_en,
  input  word_t wr_data,
  output logic  wr_rej,
  output logic  full,
  input  logic  start,
  output logic  busy,
  output word_t result,
  output logic  result_vld,
  output logic  ovf,
  output logic  mismatch,
  output logic  go_l,
  output word_t inA,
  input  logic  done,
  input  word_t sum
);
  feed_state_t state_q, state_d;
  logic [W:0]  shadow_q, shadow_d;
  word_t       result_q, result_d;
  logic        vld_q, vld_d;
  logic        ovf_q, ovf_d;
  logic        mm_q, mm_d;
  logic        rej_q, rej_d;
  logic        push, pop, empty;
  word_t       head;
  logic [W:0]  add_w;

  op_fifo #(.DEPTH(DEPTH)) u_fifo (
    .ck      (ck),
    .reset_l (reset_l),
    .push    (push),
    .wr_data (wr_data),
    .pop     (pop),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

  // host writes only land while idle, not full and non-zero
  always_comb begin
    push  = wr_en && (state_q == IDLE) && !full &&
            (wr_data != '0);
    rej_d = wr_en && !push;
  end

  // batch sequencing, shadow sum and capture
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    result_d = result_q;
    vld_d    = 1'b0;
    ovf_d    = ovf_q;
    mm_d     = mm_q;
    pop      = 1'b0;
    go_l     = 1'b1;
    inA      = '0;
    add_w    = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (empty) begin
            result_d = '0;
            ovf_d    = 1'b0;
            mm_d     = 1'b0;
            vld_d    = 1'b1;
          end else begin
            state_d = GO;
          end
        end
      end
      GO: begin
        go_l     = 1'b0;
        inA      = head;
        pop      = 1'b1;
        shadow_d = {1'b0, head};
        state_d  = STREAM;
      end
      STREAM: begin
        if (!empty) begin
          inA      = head;
          pop      = 1'b1;
          add_w    = {1'b0, shadow_q[W-1:0]} + {1'b0, head};
          shadow_d = {shadow_q[W] | add_w[W], add_w[W-1:0]};
        end else begin
          result_d = sum;
          ovf_d    = shadow_q[W];
          mm_d     = done ? (sum != shadow_q[W-1:0]) : 1'b1;
          vld_d    = 1'b1;
          shadow_d = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // all feeder state and registered outputs
  always_ff @(posedge ck or negedge reset_l) begin
    if (!reset_l) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      result_q <= '0;
      vld_q    <= 1'b0;
      ovf_q    <= 1'b0;
      mm_q     <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
      vld_q    <= vld_d;
      ovf_q    <= ovf_d;
      mm_q     <= mm_d;
      rej_q    <= rej_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign result     = result_q;
  assign result_vld = vld_q;
  assign ovf        = ovf_q;
  assign mismatch   = mm_q;
  assign wr_rej     = rej_q;
endmodule

// File: tb/tb_sum_feeder.sv
// Directed bench: sum_feeder paired with a
// behavioural sumItUp accumulator.
module tb_sum_feeder;
  import sum_pkg::*;

  logic  ck, reset_l;
  logic  wr_en, wr_rej, full, start, busy;
  word_t wr_data, result, inA, sum;
  logic  result_vld, ovf, mismatch, go_l, done;

  int total = 0;
  int bad   = 0;

  // accumulator model
  word_t acc;
  logic  active;
  logic  kill_done;
  logic  done_raw;

  assign done_raw = active && go_l && (inA == '0);
  assign done     = done_raw && !kill_done;
  assign sum      = acc;

  always @(posedge ck or negedge reset_l) begin
    if (!reset_l) begin
      acc    <= '0;
      active <= 1'b0;
    end else if (!go_l) begin
      acc    <= inA;
      active <= 1'b1;
    end else if (active && inA != '0) begin
      acc <= acc + inA;
    end else if (done_raw) begin
      active <= 1'b0;
    end
  end

  sum_feeder #(.DEPTH(8)) dut (
    .ck         (ck),
    .reset_l    (reset_l),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_rej     (wr_rej),
    .full       (full),
    .start      (start),
    .busy       (busy),
    .result     (result),
    .result_vld (result_vld),
    .ovf        (ovf),
    .mismatch   (mismatch),
    .go_l       (go_l),
    .inA        (inA),
    .done       (done),
    .sum        (sum)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic wr(input word_t d, input logic exp_rej);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
    wr_data = '0;
    chk("wr_rej", {31'b0, wr_rej}, {31'b0, exp_rej});
  endtask

  // streams the loaded ops, checks handshake and capture
  task automatic run(input word_t ops[$],
                     input word_t exp_res,
                     input logic  e_ovf,
                     input logic  e_mm);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("go_low", {31'b0, go_l}, 32'd0);
    chk("go_inA", {24'b0, inA}, {24'b0, ops[0]});
    chk("busy",   {31'b0, busy}, 32'd1);
    for (int i = 1; i < ops.size(); i++) begin
      step();
      chk("str_go", {31'b0, go_l}, 32'd1);
      chk("str_inA", {24'b0, inA}, {24'b0, ops[i]});
    end
    step();
    chk("term_inA", {24'b0, inA}, 32'd0);
    chk("term_vld", {31'b0, result_vld}, 32'd0);
    step();
    chk("vld", {31'b0, result_vld}, 32'd1);
    chk("result", {24'b0, result}, {24'b0, exp_res});
    chk("ovf", {31'b0, ovf}, {31'b0, e_ovf});
    chk("mismatch", {31'b0, mismatch}, {31'b0, e_mm});
    chk("idle", {31'b0, busy}, 32'd0);
    step();
    chk("vld_pulse", {31'b0, result_vld}, 32'd0);
    chk("res_hold", {24'b0, result}, {24'b0, exp_res});
  endtask

  initial begin
    reset_l   = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    start     = 1'b0;
    kill_done = 1'b0;
    #1;
    chk("rst_go", {31'b0, go_l}, 32'd1);
    chk("rst_inA", {24'b0, inA}, 32'd0);
    chk("rst_res", {24'b0, result}, 32'd0);
    chk("rst_vld", {31'b0, result_vld}, 32'd0);
    chk("rst_full", {31'b0, full}, 32'd0);
    repeat (2) step();
    reset_l = 1'b1;
    step();

    // basic batch
    wr(8'd3, 1'b0);
    wr(8'd5, 1'b0);
    wr(8'd7, 1'b0);
    run('{8'd3, 8'd5, 8'd7}, 8'd15, 1'b0, 1'b0);

    // overflow wraps, shadow carries
    wr(8'd200, 1'b0);
    wr(8'd100, 1'b0);
    run('{8'd200, 8'd100}, 8'h2C, 1'b1, 1'b0);

    // empty start: no handshake, immediate zero result
    start = 1'b1;
    step();
    start = 1'b0;
    chk("emp_go", {31'b0, go_l}, 32'd1);
    chk("emp_vld", {31'b0, result_vld}, 32'd1);
    chk("emp_res", {24'b0, result}, 32'd0);
    chk("emp_ovf", {31'b0, ovf}, 32'd0);
    chk("emp_busy", {31'b0, busy}, 32'd0);

    // rejected writes
    wr(8'd0, 1'b1);
    for (int i = 1; i <= 8; i++) wr(word_t'(i), 1'b0);
    chk("full", {31'b0, full}, 32'd1);
    wr(8'd99, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("bsy_go", {31'b0, go_l}, 32'd0);
    wr_en   = 1'b1;
    wr_data = 8'd50;
    step();
    wr_en   = 1'b0;
    chk("bsy_rej", {31'b0, wr_rej}, 32'd1);
    repeat (7) step();
    chk("f_term", {24'b0, inA}, 32'd0);
    step();
    chk("f_vld", {31'b0, result_vld}, 32'd1);
    chk("f_res", {24'b0, result}, 32'd36);
    chk("f_full", {31'b0, full}, 32'd0);
    step();

    // missing done in terminator cycle
    kill_done = 1'b1;
    wr(8'd4, 1'b0);
    wr(8'd6, 1'b0);
    run('{8'd4, 8'd6}, 8'd10, 1'b0, 1'b1);
    kill_done = 1'b0;
    wr(8'd1, 1'b0);
    wr(8'd2, 1'b0);
    run('{8'd1, 8'd2}, 8'd3, 1'b0, 1'b0);

    // reset mid-stream
    wr(8'd10, 1'b0);
    wr(8'd20, 1'b0);
    wr(8'd30, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("ms_inA", {24'b0, inA}, 32'd20);
    reset_l = 1'b0;
    #1;
    chk("ar_go", {31'b0, go_l}, 32'd1);
    chk("ar_inA", {24'b0, inA}, 32'd0);
    chk("ar_busy", {31'b0, busy}, 32'd0);
    chk("ar_res", {24'b0, result}, 32'd0);
    chk("ar_mm", {31'b0, mismatch}, 32'd0);
    step();
    reset_l = 1'b1;
    repeat (3) begin
      step();
      chk("ar_novld", {31'b0, result_vld}, 32'd0);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ar_empty_go", {31'b0, go_l}, 32'd1);
    chk("ar_empty_vld", {31'b0, result_vld}, 32'd1);
    chk("ar_empty_res", {24'b0, result}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
